seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream consumer of the 8-bit one-hot ring counter output (cnt) that drives an 8-digit multiplexed common-anode 7-segment display.
- Holds a 32-bit display word, 8 hex nibbles with digit i = bits [4i+3:4i].
- Accepts new words through a valid/ready handshake and applies them only at frame boundaries, so a scan never shows a mix of two words.
- Checks that the incoming digit select is one-hot and blanks the display if it is not.

Parameters:
- DIGITS, 8, number of digits; must equal the sel width. Only 8 is supported.
- LZ_DEFAULT, 1, reset value of the internal leading-zero-suppression enable (lz_en).

Ports:
- mclk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sel  in  8  one-hot digit select from the ring counter; bit i selects digit i; may hold for many mclk cycles
- wr_data  in  32  new display word
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  pending buffer is empty
- lz_cfg  in  1  leading-zero-suppression enable; sampled on lz_we
- lz_we  in  1  load lz_cfg into lz_en
- err_clr  in  1  clear sel_err
- an_n  out  8  anode enables, active-low
- seg_n  out  7  segments [6:0] = g,f,e,d,c,b,a, active-low
- frame_done  out  1  one-cycle pulse when a frame boundary occurs
- sel_err  out  1  sticky flag: sel was seen not one-hot

Behaviour:
- Reset (rst=0), asynchronous. All of the following take effect immediately:
  - disp=0, pending empty, prev_sel=0, lz_en=LZ_DEFAULT;
  - an_n=8'hFF, seg_n=7'h7F, frame_done=0, sel_err=0;
  - wr_ready=1 (wr_ready is combinational ~pend_full);
  - any accepted but unswapped word is discarded.
- Sampling and output latency:
  - sel is sampled every mclk and registered into prev_sel.
  - an_n and seg_n are registered: one cycle from a sel change to the output change.
- Decode of sel:
  - Valid one-hot with bit i set: an_n = ~(1<<i); seg_n = hex7(disp nibble i), unless that digit is blanked.
  - sel==0 or more than one bit set: an_n=FF, seg_n=7F, and sel_err is set. sel_err stays set until err_clr.
  - err_clr and a new error in the same cycle: set wins.
- Handshake:
  - A word is accepted when wr_valid && wr_ready. It goes into pending and pend_full becomes 1.
  - wr_data must be held stable while wr_valid=1 and wr_ready=0.
- Frame boundary:
  - Definition: sel==8'h01, prev_sel!=8'h01, and prev_sel is a valid one-hot value.
  - This is independent of scan direction; both 8'h80->8'h01 and 8'h02->8'h01 count.
  - At the boundary, frame_done pulses for one cycle.
  - If pend_full: disp <= pending and pend_full <= 0, in the same cycle. The digit-0 output in that cycle already uses the new disp.
- Boundary cases:
  - Write accepted in the same cycle as a boundary: not swapped in that frame. The word waits for the next boundary.
  - Transition out of an invalid sel into 8'h01: not a boundary.
  - sel held at 8'h01 over many cycles: exactly one frame_done.
- Leading-zero suppression:
  - Applies when lz_en=1.
  - Digit i (i>=1) is blanked (seg_n=7F, anode still driven) when nibbles i..7 of disp are all zero.
  - Digit 0 is never blanked.
- Hex patterns for seg_n:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Size: one always_ff for registers plus combinational decode, roughly 150-250 lines.

Decomposition:
- Package seg_scan_pkg:
  - DIGITS and NIB_W=4;
  - the 16-entry HEX7 constant array;
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF;
  - function onehot_idx returning {valid, idx[2:0]}.
- Sub-module hex7seg_dec: combinational, nibble in, seg_n out. Instantiated once on the muxed nibble.

Test Plan:
1. Reset then release; scan 01,02..80 with 4 mclk per step and no write -> an_n follows one cycle late; seg_n=40 on every digit; wr_ready=1; frame_done only on the 80->01 step.
2. Write 32'h1234ABCD mid-frame -> wr_ready drops next cycle; display unchanged until the 80->01 step. Then digit0=21 (d), digit7=79 (1), frame_done=1, wr_ready=1.
3. Two writes back-to-back within one frame -> second wr_valid stalls (wr_ready=0) until the boundary. Second word is shown one frame after the first.
4. lz_we with lz_cfg=1, disp=32'h00000305 -> digits 3..7 show seg_n=7F with anodes active; digit2=30, digit1=40, digit0=12. With disp=0, only digit0 shows 40.
5. sel=8'h03 for 2 cycles then 8'h01 -> an_n=FF, seg_n=7F, sel_err=1, no frame_done. Pulsing err_clr clears sel_err; err_clr together with sel=8'h00 keeps sel_err=1.
6. Reverse scan (80,40..01), plus rst asserted while a word is pending -> reverse 02->01 pulses frame_done. After reset the pending word is lost: next boundary shows 40 on all digits, wr_ready=1.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared constants and helpers for the multiplexed 7-segment
//                scan driver: digit count, nibble width, active-low segment
//                table, blank/off codes and one-hot decode functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    localparam int DIGITS = 8;
    localparam int NIB_W  = 4;
    localparam int IDX_W  = 3;

    localparam logic [6:0]        SEG_BLANK = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF    = 8'hFF;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when exactly one bit of s is set.
    function automatic logic is_onehot(input logic [DIGITS-1:0] s);
        return (s != '0) && ((s & (s - DIGITS'(1))) == '0);
    endfunction

    // Returns {valid, idx}; idx is the highest set bit, meaningful only when
    // valid is set.
    function automatic logic [IDX_W:0] onehot_idx(input logic [DIGITS-1:0] s);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[i]) begin
                idx = IDX_W'(i);
            end
        end
        return {is_onehot(s), idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg_dec.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg_dec
//  Description : Combinational hex nibble to active-low 7-segment decoder.
//  Ports       : i_nib   - 4-bit hex value
//                o_seg_n - segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg_dec
    import seg_scan_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [6:0]       o_seg_n
);

    assign o_seg_n = HEX7[i_nib];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Drives an 8-digit multiplexed common-anode 7-segment display
//                from a one-hot digit select. A 32-bit display word is loaded
//                through a valid/ready handshake into a pending buffer and
//                promoted to the displayed word only at frame boundaries, so
//                one scan never mixes two words. Non-one-hot selects blank the
//                display and raise a sticky error flag.
//  Ports       : mclk       - system clock
//                rst        - asynchronous active-low reset
//                sel        - one-hot digit select (bit i = digit i)
//                wr_data    - new display word, digit i = bits [4i+3:4i]
//                wr_valid   - wr_data valid
//                wr_ready   - pending buffer empty
//                lz_cfg     - leading-zero suppression enable value
//                lz_we      - load lz_cfg
//                err_clr    - clear sel_err
//                an_n       - anode enables, active-low
//                seg_n      - segments {g,f,e,d,c,b,a}, active-low
//                frame_done - one-cycle pulse at each frame boundary
//                sel_err    - sticky: sel was seen not one-hot
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGITS     = 8,      // only 8 is supported
    parameter bit LZ_DEFAULT = 1'b1
)(
    input  logic                  mclk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     sel,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  lz_cfg,
    input  logic                  lz_we,
    input  logic                  err_clr,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  frame_done,
    output logic                  sel_err
);

    import seg_scan_pkg::*;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [DIGITS-1:0]       r_prev_sel;
    logic [NIB_W*DIGITS-1:0] r_disp;
    logic [NIB_W*DIGITS-1:0] r_pend;
    logic                    r_pend_full;
    logic                    r_lz_en;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [IDX_W:0]          w_sel_dec;
    logic                    w_sel_valid;
    logic [IDX_W-1:0]        w_sel_idx;
    logic                    w_prev_valid;
    logic                    w_boundary;
    logic                    w_swap;
    logic                    w_accept;
    logic [NIB_W*DIGITS-1:0] w_disp_eff;
    logic [NIB_W-1:0]        w_nib;
    logic [6:0]              w_hex_seg;
    logic [DIGITS-1:0]       w_upper_zero;
    logic [DIGITS-1:0]       w_blank;
    logic [DIGITS-1:0]       w_an_next;
    logic [6:0]              w_seg_next;
    logic                    w_err_next;

    assign w_sel_dec    = onehot_idx(sel);
    assign w_sel_valid  = w_sel_dec[IDX_W];
    assign w_sel_idx    = w_sel_dec[IDX_W-1:0];
    assign w_prev_valid = is_onehot(r_prev_sel);

    // A frame starts on entry to digit 0 from any other valid digit, so both
    // scan directions are covered and recovery from a bad select is not.
    assign w_boundary = (sel == DIGITS'(1)) && (r_prev_sel != DIGITS'(1))
                        && w_prev_valid;

    // Swap and accept are mutually exclusive: accept needs an empty buffer,
    // swap needs a full one. A word accepted on a boundary therefore waits
    // for the following boundary.
    assign w_swap   = w_boundary && r_pend_full;
    assign w_accept = wr_valid && !r_pend_full;
    assign wr_ready = ~r_pend_full;

    // Digit 0 of the boundary cycle already shows the incoming word.
    assign w_disp_eff = w_swap ? r_pend : r_disp;
    assign w_nib      = w_disp_eff[w_sel_idx*NIB_W +: NIB_W];

    hex7seg_dec u_hex (
        .i_nib   (w_nib),
        .o_seg_n (w_hex_seg)
    );

    // w_upper_zero[i]: nibbles i..DIGITS-1 of the shown word are all zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper_zero
            assign w_upper_zero[gi] =
                ~|w_disp_eff[NIB_W*DIGITS-1:gi*NIB_W];
        end
    endgenerate

    // Digit 0 always shows, even for an all-zero word.
    assign w_blank = r_lz_en ? (w_upper_zero & ~DIGITS'(1)) : '0;

    always_comb begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_BLANK;
        if (w_sel_valid) begin
            w_an_next = ~(DIGITS'(1) << w_sel_idx);
            if (!w_blank[w_sel_idx]) begin
                w_seg_next = w_hex_seg;
            end
        end
    end

    // A new error overrides a simultaneous clear.
    assign w_err_next = !w_sel_valid || (sel_err && !err_clr);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_prev_sel  <= '0;
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_lz_en     <= LZ_DEFAULT;
            an_n        <= AN_OFF;
            seg_n       <= SEG_BLANK;
            frame_done  <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            r_prev_sel <= sel;
            an_n       <= w_an_next;
            seg_n      <= w_seg_next;
            frame_done <= w_boundary;
            sel_err    <= w_err_next;
            if (lz_we) begin
                r_lz_en <= lz_cfg;
            end
            if (w_swap) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end
            if (w_accept) begin
                r_pend      <= wr_data;
                r_pend_full <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver. A reference model
//                predicts each cycle's registered outputs when the stimulus is
//                driven; predictions queue in a scoreboard and are compared
//                one clock later. Directed constant checks cover the display
//                patterns of the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam bit LZ_DEF = 1'b0;

    localparam logic [6:0] TB_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        mclk     = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  sel      = 8'h01;
    logic [31:0] wr_data  = 32'h0;
    logic        wr_valid = 1'b0;
    logic        lz_cfg   = 1'b0;
    logic        lz_we    = 1'b0;
    logic        err_clr  = 1'b0;
    logic        wr_ready;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_done;
    logic        sel_err;

    seg_scan_driver #(
        .DIGITS     (8),
        .LZ_DEFAULT (LZ_DEF)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .sel        (sel),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .lz_cfg     (lz_cfg),
        .lz_we      (lz_we),
        .err_clr    (err_clr),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_done (frame_done),
        .sel_err    (sel_err)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] wq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_disp, m_pend;
    logic        m_full, m_lz, m_err;
    logic [7:0]  m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_disp = 32'h0;
        m_pend = 32'h0;
        m_full = 1'b0;
        m_lz   = LZ_DEF;
        m_err  = 1'b0;
        m_prev = 8'h00;
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cycle(input logic [7:0] s);
        exp_t        e;
        int          idx;
        int          ones;
        logic        pv, bnd, swap, acc;
        logic [31:0] eff;
        logic [3:0]  nib;
        sel      = s;
        wr_valid = (wq.size() != 0);
        if (wr_valid) wr_data = wq[0];
        ones = $countones(s);
        idx  = 0;
        for (int i = 0; i < 8; i++) if (s[i]) idx = i;
        pv   = ($countones(m_prev) == 1);
        bnd  = (s == 8'h01) && (m_prev != 8'h01) && pv;
        swap = bnd && m_full;
        eff  = swap ? m_pend : m_disp;
        nib  = 4'(eff >> (4 * idx));
        if (ones == 1) begin
            e.an = ~(8'h01 << idx);
            if (m_lz && idx != 0 && (eff >> (4 * idx)) == 32'h0) e.seg = 7'h7F;
            else                                                e.seg = TB_HEX[nib];
        end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
        end
        e.fd  = bnd;
        e.err = (ones != 1) || (m_err && !err_clr);
        acc   = wr_valid && !m_full;
        if (swap) begin m_disp = m_pend; m_full = 1'b0; end
        if (acc)  begin m_pend = wr_data; m_full = 1'b1; end
        e.rdy  = !m_full;
        m_prev = s;
        if (lz_we) m_lz = lz_cfg;
        m_err  = e.err;
        sb.push_back(e);
        @(posedge mclk);
        #1;
        e = sb.pop_front();
        chk("an_n",       32'(an_n),       32'(e.an));
        chk("seg_n",      32'(seg_n),      32'(e.seg));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("sel_err",    32'(sel_err),    32'(e.err));
        chk("wr_ready",   32'(wr_ready),   32'(e.rdy));
        if (acc) void'(wq.pop_front());
        lz_we   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic run_steps(input bit fwd, input int from, input int to, input int hold);
        logic [7:0] s;
        for (int d = from; d <= to; d++) begin
            s = fwd ? (8'h01 << d) : (8'h80 >> d);
            repeat (hold) cycle(s);
        end
    endtask

    initial begin
        model_reset();

        // Reset values
        #3 rst = 1'b0;
        #1;
        chk("rst_an",    32'(an_n),       32'hFF);
        chk("rst_seg",   32'(seg_n),      32'h7F);
        chk("rst_fd",    32'(frame_done), 32'h0);
        chk("rst_err",   32'(sel_err),    32'h0);
        chk("rst_ready", 32'(wr_ready),   32'h1);
        @(posedge mclk);
        @(posedge mclk);
        #1 rst = 1'b1;

        // 1: plain forward scan, empty display
        run_steps(1'b1, 0, 7, 4);
        chk("t1_no_fd", 32'(frame_done), 32'h0);
        cycle(8'h01);
        chk("t1_fd",  32'(frame_done), 32'h1);
        chk("t1_an0", 32'(an_n),       32'hFE);
        chk("t1_seg", 32'(seg_n),      32'h40);
        repeat (3) cycle(8'h01);
        chk("t1_hold_fd", 32'(frame_done), 32'h0);
        run_steps(1'b1, 1, 7, 4);

        // 2: single write mid-frame
        repeat (4) cycle(8'h01);
        run_steps(1'b1, 1, 3, 4);
        wq.push_back(32'h1234ABCD);
        cycle(8'h10);
        chk("t2_ready_drop", 32'(wr_ready), 32'h0);
        chk("t2_old_seg",    32'(seg_n),    32'h40);
        run_steps(1'b1, 4, 7, 4);
        cycle(8'h01);
        chk("t2_d0_seg", 32'(seg_n),      32'h21);
        chk("t2_fd",     32'(frame_done), 32'h1);
        chk("t2_ready",  32'(wr_ready),   32'h1);
        repeat (3) cycle(8'h01);
        run_steps(1'b1, 1, 6, 4);
        cycle(8'h80);
        chk("t2_d7_seg", 32'(seg_n), 32'h79);
        chk("t2_d7_an",  32'(an_n),  32'h7F);
        repeat (3) cycle(8'h80);

        // 3: back-to-back writes, second stalls a frame
        repeat (4) cycle(8'h01);
        wq.push_back(32'h00000007);
        wq.push_back(32'h0000000E);
        run_steps(1'b1, 1, 7, 4);
        chk("t3_stall", 32'(wr_ready), 32'h0);
        cycle(8'h01);
        chk("t3_first_seg", 32'(seg_n),      32'h78);
        chk("t3_first_fd",  32'(frame_done), 32'h1);
        repeat (3) cycle(8'h01);
        chk("t3_second_pending", 32'(wr_ready), 32'h0);
        run_steps(1'b1, 1, 7, 4);
        cycle(8'h01);
        chk("t3_second_seg", 32'(seg_n), 32'h06);
        repeat (3) cycle(8'h01);

        // 4: leading-zero suppression
        lz_cfg = 1'b1;
        lz_we  = 1'b1;
        wq.push_back(32'h00000305);
        run_steps(1'b1, 1, 7, 4);
        cycle(8'h01);
        chk("t4_d0", 32'(seg_n), 32'h12);
        cycle(8'h02);
        chk("t4_d1", 32'(seg_n), 32'h40);
        cycle(8'h04);
        chk("t4_d2", 32'(seg_n), 32'h30);
        cycle(8'h08);
        chk("t4_d3_seg", 32'(seg_n), 32'h7F);
        chk("t4_d3_an",  32'(an_n),  32'hF7);
        run_steps(1'b1, 4, 7, 2);
        wq.push_back(32'h00000000);
        run_steps(1'b1, 0, 7, 2);
        cycle(8'h01);
        chk("t4_zero_d0", 32'(seg_n), 32'h40);
        cycle(8'h02);
        chk("t4_zero_d1_seg", 32'(seg_n), 32'h7F);
        chk("t4_zero_d1_an",  32'(an_n),  32'hFD);
        run_steps(1'b1, 2, 7, 2);

        // 5: invalid selects and the sticky error
        repeat (2) cycle(8'h03);
        chk("t5_an",  32'(an_n),    32'hFF);
        chk("t5_seg", 32'(seg_n),   32'h7F);
        chk("t5_err", 32'(sel_err), 32'h1);
        cycle(8'h01);
        chk("t5_no_fd", 32'(frame_done), 32'h0);
        cycle(8'h01);
        err_clr = 1'b1;
        cycle(8'h02);
        chk("t5_clr", 32'(sel_err), 32'h0);
        err_clr = 1'b1;
        cycle(8'h00);
        chk("t5_set_wins", 32'(sel_err), 32'h1);
        err_clr = 1'b1;
        cycle(8'h04);
        chk("t5_clr2", 32'(sel_err), 32'h0);

        // 6: reverse scan, then reset with a word pending
        run_steps(1'b0, 0, 6, 4);
        cycle(8'h01);
        chk("t6_rev_fd", 32'(frame_done), 32'h1);
        repeat (3) cycle(8'h01);
        wq.push_back(32'hFFFFFFFF);
        run_steps(1'b0, 0, 3, 4);
        chk("t6_pending", 32'(wr_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("t6_rst_an",    32'(an_n),     32'hFF);
        chk("t6_rst_seg",   32'(seg_n),    32'h7F);
        chk("t6_rst_ready", 32'(wr_ready), 32'h1);
        model_reset();
        sb.delete();
        wq.delete();
        wr_valid = 1'b0;
        @(posedge mclk);
        #1 rst = 1'b1;
        run_steps(1'b0, 3, 6, 4);
        cycle(8'h01);
        chk("t6_after_fd",    32'(frame_done), 32'h1);
        chk("t6_after_seg",   32'(seg_n),      32'h40);
        chk("t6_after_ready", 32'(wr_ready),   32'h1);
        run_steps(1'b0, 0, 7, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
